data_memory_pipe: RTL and testbench

- Parametrised successor to the single-cycle data memory of the ARM CPU datapath.
- Byte-addressed and word-organised, with 8/16/32/64-bit loads and stores, and sign/zero extension on loads.
- Configurable access latency, with valid/ready handshakes on both the request and response sides.
- Sits between the MEM pipeline stage and the backing array; the stage stalls on req_ready / resp_valid.

---
 rtl/data_memory_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_data_memory_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipe.sv
// data_memory_pipe
//   Byte-addressed, word-organised data memory with a configurable access
//   latency and valid/ready handshakes on the request and response sides.
//   Supports byte/half/word32/dword loads and stores. Loads are sign- or
//   zero-extended. At most one request is in flight at a time.
//
//   Compile-time option:
//     DMEM_MISALIGN_FAULT_EN  - when defined, a misaligned half/word32/dword
//                               access faults. When undefined, the low
//                               address bits are cleared and the access
//                               completes at the aligned address.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   req_valid/ready request handshake
//   req_write       1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word32, 11 dword (DATA_W = 64 only)
//   req_signed      loads: 1 = sign-extend, 0 = zero-extend
//   address         byte address
//   InData          store data (low bits)
//   resp_valid/ready response handshake
//   outRead         extended load data; 0 for stores and faults
//   fault           out-of-range, illegal-size or misaligned access
module data_memory_pipe #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 64,
    parameter int LATENCY    = 2,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] InData,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] outRead,
    output logic              fault
);
    localparam int         NB        = DATA_W / 8;
    localparam int         B         = $clog2(NB);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam int         CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [1:0] SIZE_FULL = 2'(B);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Byte enables for an access of 2**sz bytes starting at lane ln.
    function automatic logic [NB-1:0] lane_enables(input logic [1:0] sz, input logic [B-1:0] ln);
        logic [NB-1:0] base;
        base = NB'((32'd1 << (32'd1 << sz)) - 32'd1);
        return base << ln;
    endfunction

    // Extend the low 2**sz bytes of w to DATA_W bits.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] w,
                                                      input logic [1:0]        sz,
                                                      input logic              sgn);
        int                       sh;
        logic signed [DATA_W-1:0] t;
        if (sz >= SIZE_FULL) return w;
        sh = DATA_W - (8 << sz);
        t  = signed'(w << sh);
        if (sgn) return $unsigned(t >>> sh);
        return (w << sh) >> sh;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              fault_q, fault_d;

    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              mem_we;
    logic [IDX_W-1:0]  idx;
    logic [B-1:0]      lane_raw;
    logic [B-1:0]      lane;
    logic [B-1:0]      size_mask;
    logic              out_of_range;
    logic              bad_size;
    logic              flt;
    logic [NB-1:0]     byte_en;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] mem_rd [DEPTH];

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign outRead    = out_q;
    assign fault      = fault_q;

    assign idx          = addr_q[B +: IDX_W];
    assign lane_raw     = addr_q[B-1:0];
    assign size_mask    = B'((32'd1 << size_q) - 32'd1);
    // Any set bit above the word index is out of range; nothing wraps.
    assign out_of_range = |(addr_q >> (B + IDX_W));
    assign bad_size     = (DATA_W == 32) && (size_q == 2'b11);

`ifdef DMEM_MISALIGN_FAULT_EN
    logic misaligned;
    assign misaligned = |(lane_raw & size_mask);
    assign lane       = lane_raw;
    assign flt        = out_of_range || bad_size || misaligned;
`else
    assign lane       = lane_raw & ~size_mask;
    assign flt        = out_of_range || bad_size;
`endif

    assign byte_en  = lane_enables(size_q, lane);
    assign wdata_sh = wdata_q << {lane, 3'b000};
    assign rd_word  = mem_rd[idx] >> {lane, 3'b000};
    // Commit happens on the BUSY edge with the counter at zero.
    assign mem_we   = (state_q == BUSY) && (cnt_q == '0) && write_q && !flt;

    // Backing array: one register per word, initialised at time zero only.
    for (genvar j = 0; j < DEPTH; j++) begin : g_word
        logic [DATA_W-1:0] word_q = (INIT_INDEX != 0) ? DATA_W'(j) : '0;
        always_ff @(posedge clk) begin
            if (mem_we && (idx == IDX_W'(j))) begin
                for (int k = 0; k < NB; k++) begin
                    if (byte_en[k]) word_q[k*8 +: 8] <= wdata_sh[k*8 +: 8];
                end
            end
        end
        assign mem_rd[j] = word_q;
    end

    // Request capture: data registers, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= address;
            wdata_q  <= InData;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        out_d        = out_q;
        fault_d      = fault_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    fault_d      = flt;
                    out_d        = (write_q || flt) ? '0 : load_extend(rd_word, size_q, signed_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    out_d        = '0;
                    fault_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            out_q        <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            out_q        <= out_d;
            fault_q      <= fault_d;
        end
    end
endmodule

// File: tb/tb_data_memory_pipe.sv
module tb_data_memory_pipe;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [63:0] address = '0;
    logic [63:0] InData = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] outRead;
    logic        fault;

    data_memory_pipe #(
        .DATA_W(64), .DEPTH(32), .ADDR_W(64), .LATENCY(LATENCY), .INIT_INDEX(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .address(address), .InData(InData),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .outRead(outRead), .fault(fault)
    );

    always #5 clk = ~clk;

`ifdef DMEM_MISALIGN_FAULT_EN
    localparam logic [63:0] W4_AFTER   = 64'h0000_0000_0000_AB04;
    localparam logic [63:0] W4_S32     = 64'h0000_0000_0000_AB04;
    localparam logic        BEEF_FAULT = 1'b1;
`else
    localparam logic [63:0] W4_AFTER   = 64'h0000_0000_BEEF_AB04;
    localparam logic [63:0] W4_S32     = 64'hFFFF_FFFF_BEEF_AB04;
    localparam logic        BEEF_FAULT = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference memory as a flat little-endian byte array.
    logic [7:0] bmem [256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [63:0] a, input logic [63:0] d,
                                  output logic [63:0] eo, output logic ef);
        int          n;
        logic [63:0] base;
        logic [63:0] v;
        logic [63:0] half_range;
        n  = 1 << sz;
        eo = '0;
        ef = 1'b0;
        v  = '0;
        if (a >= 64'd256) ef = 1'b1;
`ifdef DMEM_MISALIGN_FAULT_EN
        if (a % 64'(n) != 0) ef = 1'b1;
        base = a;
`else
        base = a - (a % 64'(n));
`endif
        if (ef) return;
        if (w) begin
            for (int i = 0; i < n; i++) bmem[int'(base[7:0]) + i] = d[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) v = v + (64'(bmem[int'(base[7:0]) + i]) << (8*i));
            if (sg && n < 8) begin
                half_range = 64'd1 << (8*n - 1);
                if (v >= half_range) v = v - (half_range << 1);
            end
            eo = v;
        end
    endfunction

    // One full transaction. Called with inputs settled #1 after a rising edge.
    task automatic transact(input string tag, input logic w, input logic [1:0] sz,
                            input logic sg, input logic [63:0] a, input logic [63:0] d,
                            input int hold, input logic poke,
                            output logic [63:0] rd, output logic f);
        int n;
        rd = '0;
        f  = 1'b0;
        resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            check({tag, " req_ready timeout"}, 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        address = a; InData = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " busy req_ready"}, 64'(req_ready), 64'd0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, 64'(n), 64'(LATENCY));
        rd = outRead;
        f  = fault;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11;
                address = 64'h30; InData = 64'hDEAD;
            end
            @(posedge clk); #1;
            check({tag, " hold resp_valid"}, 64'(resp_valid), 64'd1);
            check({tag, " hold outRead"}, outRead, rd);
            check({tag, " hold fault"}, 64'(fault), 64'(f));
            check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, " post resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, " post req_ready"}, 64'(req_ready), 64'd1);
        check({tag, " post outRead"}, outRead, 64'd0);
        check({tag, " post fault"}, 64'(fault), 64'd0);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] eo;
        logic        ef;
    } vec_t;

    localparam int NVEC = 15;
    vec_t        tbl [NVEC];
    logic [63:0] rd, eo, a, d;
    logic        f, ef, w, sg;
    logic [1:0]  sz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
        for (int j = 0; j < 32; j++) bmem[j*8] = 8'(j);

        //            w     sz     sg    addr                    data                    exp out                 fault
        tbl[0]  = '{1'b0, 2'd3, 1'b0, 64'h18,                 64'h0,                  64'h3,                  1'b0};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 64'h21,                 64'hAB,                 64'h0,                  1'b0};
        tbl[2]  = '{1'b0, 2'd3, 1'b0, 64'h20,                 64'h0,                  64'hAB04,               1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 64'h21,                 64'h0,                  64'hFFFF_FFFF_FFFF_FFAB, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 64'h21,                 64'h0,                  64'hAB,                 1'b0};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 64'h20,                 64'h0,                  64'hFFFF_FFFF_FFFF_AB04, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 64'h20,                 64'h0,                  64'hAB04,               1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 64'h23,                 64'hBEEF,               64'h0,                  BEEF_FAULT};
        tbl[8]  = '{1'b0, 2'd3, 1'b0, 64'h20,                 64'h0,                  W4_AFTER,               1'b0};
        tbl[9]  = '{1'b0, 2'd2, 1'b1, 64'h20,                 64'h0,                  W4_S32,                 1'b0};
        tbl[10] = '{1'b0, 2'd3, 1'b0, 64'h100,                64'h0,                  64'h0,                  1'b1};
        tbl[11] = '{1'b1, 2'd3, 1'b0, 64'h100,                64'h55,                 64'h0,                  1'b1};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 64'h28,                 64'h0,                  64'h5,                  1'b0};
        tbl[13] = '{1'b0, 2'd3, 1'b0, 64'hFFFF_0000_0000_0020, 64'h0,                 64'h0,                  1'b1};
        tbl[14] = '{1'b0, 2'd2, 1'b1, 64'h18,                 64'h0,                  64'h3,                  1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset outRead", outRead, 64'd0);
        check("reset fault", 64'(fault), 64'd0);
        rst = 1'b0;
        #1;
        check("after reset req_ready", 64'(req_ready), 64'd1);

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            transact($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a,
                     tbl[i].d, 0, 1'b0, rd, f);
            check($sformatf("vec%0d outRead", i), rd, tbl[i].eo);
            check($sformatf("vec%0d fault", i), 64'(f), 64'(tbl[i].ef));
            model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d, eo, ef);
        end

        // Back-pressure: response held 5 cycles while a store is offered and must be ignored
        transact("hold", 1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 5, 1'b1, rd, f);
        check("hold outRead", rd, W4_AFTER);
        transact("ignored", 1'b0, 2'd3, 1'b0, 64'h30, 64'h0, 0, 1'b0, rd, f);
        check("ignored store word6", rd, 64'h6);

        // Reset between acceptance and commit discards the store
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_signed = 1'b0;
        address = 64'h08; InData = 64'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort rst req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort resp_valid", 64'(resp_valid), 64'd0);
        check("abort outRead", outRead, 64'd0);
        check("abort fault", 64'(fault), 64'd0);
        check("abort req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        check("abort no late resp", 64'(resp_valid), 64'd0);
        transact("abort load", 1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 0, 1'b0, rd, f);
        check("abort word1", rd, 64'h1);

        // Randomised traffic against the byte-array model
        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 64'($urandom_range(256, 4095));
                1:       a = {32'($urandom), 32'($urandom_range(0, 255))} | 64'h1_0000_0000;
                default: a = 64'($urandom_range(0, 255));
            endcase
            d = {32'($urandom), 32'($urandom)};
            model(w, sz, sg, a, d, eo, ef);
            transact($sformatf("rnd%0d", i), w, sz, sg, a, d, $urandom_range(0, 2), 1'b0, rd, f);
            check($sformatf("rnd%0d outRead", i), rd, eo);
            check($sformatf("rnd%0d fault", i), 64'(f), 64'(ef));
        end

        // Full readback
        for (int j = 0; j < 32; j++) begin
            model(1'b0, 2'd3, 1'b0, 64'(j * 8), 64'h0, eo, ef);
            transact($sformatf("rb%0d", j), 1'b0, 2'd3, 1'b0, 64'(j * 8), 64'h0, 0, 1'b0, rd, f);
            check($sformatf("rb%0d word", j), rd, eo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
